ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Sits beside the existing keyboard receive path on the shared PS2_CLK/PS2_DATA open-collector lines. The top level drives each line low through an output-enable and otherwise leaves it as 'z'.
- Implements request-to-send, bit shifting on device-generated clock edges, odd parity, stop bit, ACK check and timeout.
- The keyboard's 0xFA reply arrives afterwards through the receive path.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles PS2_CLK is held low for request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000, maximum clk cycles between consecutive device falling clock edges (15 ms) before aborting.

Ports:
- clk  in  1  system clock.
- out_rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  request; byte accepted when tx_valid && tx_ready in the same cycle.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS2_CLK line level.
- ps2_data_in  in  1  raw PS2_DATA line level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_data_oe  out  1  1 = pull PS2_DATA low.
- busy  out  1  transfer in progress; top level uses it to ignore receive-path output.
- done  out  1  one-cycle pulse at end of every accepted transfer, success or failure.
- err  out  1  valid with done: 1 = NACK or timeout, 0 = ACK received.

Behaviour:
- Reset is asynchronous and releases the bus immediately.
  - Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, err=0.
  - State=IDLE, bit counter=0, timer=0.
  - A reset mid-transfer aborts with no done pulse.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
  - fall = prev_sync_clk & ~sync_clk: a one-cycle strobe, 3 cycles after the line edge.
- On accept, latch shift = {1'b1 stop, ~^tx_data parity, tx_data}. Bits shift LSB first.
- IDLE: both oe=0; tx_ready=1. On accept go to INHIBIT and set busy=1.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe=0.
- REQ (1 cycle): ps2_data_oe=1, which is the start bit 0. Then ps2_clk_oe=0 and go to SEND; timer cleared.
- SEND: on each fall, increment edge count k (1..10).
  - k=1..8: ps2_data_oe = ~tx_data[k-1].
  - k=9: ps2_data_oe = ~parity.
  - k=10: ps2_data_oe=0 (stop bit 1 released); go to ACK.
  - Data changes only in the cycle of fall. The device samples on the rising edge.
- ACK: on the 11th fall, sample sync_data.
  - 0 = ack_ok.
  - 1 = nack; set err and go directly to DONE.
  - If ack_ok, go to WAIT_HIGH.
- WAIT_HIGH: wait until sync_clk=1 and sync_data=1, then go to DONE.
- DONE (1 cycle): done=1, err as recorded. Next state is IDLE; busy=0 from the IDLE cycle.
- Timeout:
  - The timer runs in SEND, ACK and WAIT_HIGH and clears on every fall.
  - When the timer reaches TIMEOUT_CYCLES: release both oe, set err=1, go to DONE.
- err holds its value until the next accept.
- tx_valid while busy is ignored and not queued.
- A fall seen in IDLE or INHIBIT is ignored: device-originated traffic is not this block's concern.
- The timer is 21 bits. The INHIBIT counter is 14 bits. The edge counter is 4 bits and saturates.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_HIGH, DONE;
  - command constants: CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RESP_ACK=8'hFA.
- One sub-module: ps2_line_sync. It contains the 2-flop synchronizers for clk and data plus the fall-edge strobe, and is reusable by the receive side.

Test Plan:
- Send 0xED with a device model clocking 11 edges at 12 kHz and driving ACK low:
  - ps2_clk_oe high exactly 10000 cycles, then data_oe=1.
  - Device-sampled bits: 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulse, err=0.
- Send 0x01: parity bit sampled 0. Send 0x00: parity bit sampled 1. Both end with err=0.
- NACK: device leaves data high at the 11th edge -> done with err=1, both oe=0, tx_ready=1 the next cycle.
- Timeout: device never clocks after REQ -> after 1500000 cycles, both oe=0, done pulse with err=1.
- Assert out_rst between the 5th and 6th falls -> both oe=0 with no clock edge; no done pulse. After reset, a full 0xF4 transfer succeeds.
- Pulse tx_valid with 0xFF during an 0xED transfer -> ignored. Only 0xED appears on the bus; a new request after done is accepted.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding and
// keyboard command constants used by the tx and rx paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_HIGH,
    DONE
  } state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between the host logic
// and the PS/2 transmitter.
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, err
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for raw PS2_CLK/PS2_DATA plus a
// one-cycle strobe on each falling clock edge.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_sync_clk,
  output logic o_sync_data,
  output logic o_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;

  // Idle bus is high; resetting to 1 avoids a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign o_sync_clk  = r_clk_sync[1];
  assign o_sync_data = r_data_sync[1];
  assign o_fall      = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, bit shifting
// on device clock falls, odd parity, ACK check and timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic         clk,
  input  logic         out_rst,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam logic [13:0] INH_LAST = 14'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);

  logic w_sync_clk;
  logic w_sync_data;
  logic w_fall;

  ps2_line_sync u_sync (
    .clk         (clk),
    .rst         (out_rst),
    .i_ps2_clk   (ps2_clk_in),
    .i_ps2_data  (ps2_data_in),
    .o_sync_clk  (w_sync_clk),
    .o_sync_data (w_sync_data),
    .o_fall      (w_fall)
  );

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_shift;
  logic        r_data_oe;
  logic        r_err;
  logic [3:0]  r_bit_cnt;
  logic [13:0] r_inh_cnt;
  logic [20:0] r_timer;

  logic w_accept;
  logic w_timing;
  logic w_timed;

  assign w_accept = (r_state == IDLE) && tx.tx_valid;
  assign w_timing = (r_state == SEND) || (r_state == ACK)
                 || (r_state == WAIT_HIGH);
  assign w_timed  = w_timing && (r_timer == TO_LAST);

  always_ff @(posedge clk or posedge out_rst) begin
    if (out_rst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (tx.tx_valid) w_next = INHIBIT;
      INHIBIT:   if (r_inh_cnt == INH_LAST) w_next = REQ;
      REQ:       w_next = SEND;
      SEND: begin
        if (w_timed) w_next = DONE;
        else if (w_fall && r_bit_cnt == 4'd9) w_next = ACK;
      end
      ACK: begin
        if (w_timed) w_next = DONE;
        else if (w_fall) w_next = w_sync_data ? DONE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (w_timed) w_next = DONE;
        else if (w_sync_clk && w_sync_data) w_next = DONE;
      end
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge out_rst) begin
    if (out_rst) begin
      r_shift   <= '0;
      r_data_oe <= 1'b0;
      r_err     <= 1'b0;
      r_bit_cnt <= '0;
      r_inh_cnt <= '0;
      r_timer   <= '0;
    end else begin
      if (w_accept) begin
        r_shift   <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
        r_err     <= 1'b0;
        r_bit_cnt <= '0;
        r_inh_cnt <= '0;
        r_data_oe <= 1'b0;
      end
      if (r_state == INHIBIT) r_inh_cnt <= r_inh_cnt + 14'd1;
      if (r_state == REQ) r_data_oe <= 1'b1;
      // Line is driven low for a 0 bit, so oe is the inverted bit.
      if (r_state == SEND && w_fall) begin
        r_data_oe <= ~r_shift[0];
        r_shift   <= {1'b0, r_shift[9:1]};
      end
      if ((r_state == SEND || r_state == ACK) && w_fall
          && r_bit_cnt != 4'hF)
        r_bit_cnt <= r_bit_cnt + 4'd1;
      if (w_timing && !w_fall) r_timer <= r_timer + 21'd1;
      else                     r_timer <= '0;
      if (w_timed)
        r_err <= 1'b1;
      else if (r_state == ACK && w_fall && w_sync_data)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    ps2_clk_oe  = (r_state == INHIBIT);
    ps2_data_oe = (r_state == REQ)
               || ((r_state == SEND) && r_data_oe);
    tx.tx_ready = (r_state == IDLE);
    tx.busy     = (r_state != IDLE);
    tx.done     = (r_state == DONE);
    tx.err      = r_err;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device
// on a wired-AND bus.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic out_rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic clk_line;
  logic data_line;

  always #5 clk = ~clk;

  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .out_rst     (out_rst),
    .tx          (bus),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  typedef struct {
    logic [10:0] frame;
    logic        err;
    bit          chk_frame;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_err = 0;
  logic [10:0] obs_frame;
  int          mon_run = 0;
  bit          mon_prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as the device should see it: start, data LSB first,
  // parity making the count of ones odd, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      if (d[i]) ones++;
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  always @(negedge clk) begin
    if (out_rst) begin
      mon_run = 0;
      mon_prev_done = 1'b0;
    end else begin
      if (mon_prev_done)
        check("ready_after_done", {bus.tx_ready, bus.busy}, 2'b10);
      mon_prev_done = bus.done;
      if (ps2_clk_oe) begin
        mon_run++;
      end else if (mon_run > 0) begin
        check("inhibit_len", mon_run, INH);
        check("req_data_oe", ps2_data_oe, 1);
        mon_run = 0;
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          mon_e = exp_q.pop_front();
          check("err", bus.err, mon_e.err);
          check("oe_at_done", {ps2_clk_oe, ps2_data_oe}, 2'b00);
          if (mon_e.chk_frame) check("frame", obs_frame, mon_e.frame);
        end
      end
    end
  end

  task automatic start(input logic [7:0] d, input bit e_err,
                       input bit chk);
    int t;
    t = 0;
    while (!bus.tx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", bus.tx_ready, 1);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    obs_frame    = '0;
    exp_q.push_back('{frame_of(d), e_err, chk});
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    check("busy_after_accept", {bus.busy, bus.tx_ready}, 2'b10);
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (!ps2_clk_oe && t < 1000) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (ps2_clk_oe && t < INH + 1000) begin
      @(negedge clk);
      t++;
    end
    check("request_released", ps2_clk_oe, 0);
  endtask

  task automatic device(input bit nack, input int n_edges);
    logic [10:0] f;
    f = '0;
    wait_req();
    repeat (HALF) @(negedge clk);
    f[0] = data_line;
    for (int k = 1; k <= n_edges; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      f[k] = data_line;
      dev_clk = 1'b1;
      if (k < n_edges) repeat (HALF) @(negedge clk);
    end
    if (n_edges == 10) begin
      obs_frame = f;
      repeat (HALF) @(negedge clk);
      if (!nack) dev_data = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < TO + INH + 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int mode);
    start(d, mode != 0, mode != 2);
    if (mode != 2) device(mode == 1, 10);
    wait_idle();
  endtask

  initial begin
    int n;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state",
          {ps2_clk_oe, ps2_data_oe, bus.tx_ready, bus.busy,
           bus.done, bus.err}, 6'b001000);
    out_rst = 1'b0;
    repeat (3) @(negedge clk);

    send(ps2_pkg::CMD_SET_LED, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'($urandom), 1);

    start(8'($urandom), 1'b1, 1'b0);
    wait_req();
    n = 0;
    while (!bus.done && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TO + 1);
    wait_idle();

    start(8'h00, 1'b0, 1'b1);
    device(1'b0, 5);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    check("data_oe_before_reset", ps2_data_oe, 1);
    out_rst = 1'b1;
    #1;
    check("oe_async_reset", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("state_in_reset", {bus.tx_ready, bus.busy, bus.done, bus.err},
          4'b1000);
    out_rst = 1'b0;
    repeat (HALF * 4) @(negedge clk);
    send(ps2_pkg::CMD_ENABLE, 0);

    start(ps2_pkg::CMD_SET_LED, 1'b0, 1'b1);
    fork
      device(1'b0, 10);
      begin
        repeat (INH + 200) @(negedge clk);
        bus.tx_data  = ps2_pkg::CMD_RESET;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    join
    wait_idle();
    send(8'($urandom), 0);

    repeat (6) send(8'($urandom), int'($urandom_range(0, 1)));

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
